// File: rtl/addr_map_pipe.sv
// Two-stage pipelined DRAM address mapper: stage 1 captures address and mode,
// stage 2 holds the decoded rank/BG/bank/row/col/offset/ignore fields.
module addr_map_pipe #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RANK_BITS   = 1,
  parameter int unsigned BG_BITS     = 2,
  parameter int unsigned BANK_BITS   = 2,
  parameter int unsigned ROW_BITS    = 13,
  parameter int unsigned COL_BITS    = 10,
  parameter int unsigned OFFSET_BITS = 3,
  localparam int unsigned IGNORE_BITS = ADDR_W - RANK_BITS - BG_BITS - BANK_BITS
                                        - ROW_BITS - COL_BITS - OFFSET_BITS
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RANK_BITS-1:0]   out_rank,
  output logic [BG_BITS-1:0]     out_bg,
  output logic [BANK_BITS-1:0]   out_bank,
  output logic [ROW_BITS-1:0]    out_row,
  output logic [COL_BITS-1:0]    out_col,
  output logic [OFFSET_BITS-1:0] out_offset,
  output logic [IGNORE_BITS-1:0] out_ignore,
  output logic                   out_oor,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_mode,
  output logic [1:0]             cur_mode,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {
    MODE_RORABGBACO = 2'd0,
    MODE_BG_ILV     = 2'd1,
    MODE_XOR_HASH   = 2'd2,
    MODE_ILLEGAL    = 2'd3
  } mode_e;

  localparam int unsigned ROW_LSB  = OFFSET_BITS + COL_BITS + BANK_BITS + BG_BITS;
  localparam int unsigned RANK_LSB = ROW_LSB + ROW_BITS;
  localparam int unsigned IGN_LSB  = RANK_LSB + RANK_BITS;

  logic                   s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]      s1_addr_q, s1_addr_d;
  mode_e                  s1_mode_q, s1_mode_d;
  mode_e                  cur_mode_q, cur_mode_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [RANK_BITS-1:0]   rank_q, rank_d;
  logic [BG_BITS-1:0]     bg_q, bg_d;
  logic [BANK_BITS-1:0]   bank_q, bank_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [COL_BITS-1:0]    col_q, col_d;
  logic [OFFSET_BITS-1:0] off_q, off_d;
  logic [IGNORE_BITS-1:0] ign_q, ign_d;

  logic [RANK_BITS-1:0]   dec_rank;
  logic [BG_BITS-1:0]     dec_bg;
  logic [BANK_BITS-1:0]   dec_bank;
  logic [ROW_BITS-1:0]    dec_row;
  logic [COL_BITS-1:0]    dec_col;
  logic [OFFSET_BITS-1:0] dec_off;
  logic [IGNORE_BITS-1:0] dec_ign;

  logic s2_adv, s1_adv, cfg_fire, in_fire;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign cfg_ready = !s1_valid_q && !s2_valid_q;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_ready  = s1_adv && !cfg_fire;
  assign in_fire   = in_valid && in_ready;

  // Decode uses the mode captured alongside the address, never cur_mode.
  always_comb begin
    dec_off  = s1_addr_q[0 +: OFFSET_BITS];
    dec_col  = s1_addr_q[OFFSET_BITS +: COL_BITS];
    dec_bank = s1_addr_q[OFFSET_BITS + COL_BITS +: BANK_BITS];
    dec_bg   = s1_addr_q[OFFSET_BITS + COL_BITS + BANK_BITS +: BG_BITS];
    dec_row  = s1_addr_q[ROW_LSB +: ROW_BITS];
    dec_rank = s1_addr_q[RANK_LSB +: RANK_BITS];
    dec_ign  = s1_addr_q[IGN_LSB +: IGNORE_BITS];
    if (s1_mode_q == MODE_BG_ILV) begin
      dec_bg   = s1_addr_q[OFFSET_BITS +: BG_BITS];
      dec_col  = s1_addr_q[OFFSET_BITS + BG_BITS +: COL_BITS];
      dec_bank = s1_addr_q[OFFSET_BITS + BG_BITS + COL_BITS +: BANK_BITS];
    end else if (s1_mode_q == MODE_XOR_HASH) begin
      dec_bank = dec_bank ^ dec_row[0 +: BANK_BITS];
      dec_bg   = dec_bg ^ dec_row[BANK_BITS +: BG_BITS];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    rank_d     = rank_q;
    bg_d       = bg_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    off_d      = off_q;
    ign_d      = ign_q;
    cur_mode_d = cur_mode_q;
    cfg_err_d  = cfg_fire && (cfg_mode == MODE_ILLEGAL);

    if (s1_adv) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_addr_d = in_addr;
      s1_mode_d = cur_mode_q;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rank_d = dec_rank;
        bg_d   = dec_bg;
        bank_d = dec_bank;
        row_d  = dec_row;
        col_d  = dec_col;
        off_d  = dec_off;
        ign_d  = dec_ign;
      end
    end

    if (cfg_fire && (cfg_mode != MODE_ILLEGAL)) cur_mode_d = mode_e'(cfg_mode);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_mode_q  <= MODE_RORABGBACO;
      cur_mode_q <= MODE_RORABGBACO;
      cfg_err_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      rank_q     <= '0;
      bg_q       <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      off_q      <= '0;
      ign_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_mode_q  <= s1_mode_d;
      cur_mode_q <= cur_mode_d;
      cfg_err_q  <= cfg_err_d;
      s2_valid_q <= s2_valid_d;
      rank_q     <= rank_d;
      bg_q       <= bg_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      off_q      <= off_d;
      ign_q      <= ign_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_rank   = rank_q;
  assign out_bg     = bg_q;
  assign out_bank   = bank_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_offset = off_q;
  assign out_ignore = ign_q;
  assign out_oor    = |ign_q;
  assign cur_mode   = cur_mode_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_addr_map_pipe.sv
// Directed + randomized bench for addr_map_pipe against an arithmetic
// field-extraction model and an in-flight request queue.
module tb_addr_map_pipe;

  logic        CLK = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_rank;
  logic [1:0]  out_bg;
  logic [1:0]  out_bank;
  logic [12:0] out_row;
  logic [9:0]  out_col;
  logic [2:0]  out_offset;
  logic [0:0]  out_ignore;
  logic        out_oor;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [1:0]  cur_mode;
  logic        cfg_err;

  addr_map_pipe #(
    .ADDR_W(32), .RANK_BITS(1), .BG_BITS(2), .BANK_BITS(2),
    .ROW_BITS(13), .COL_BITS(10), .OFFSET_BITS(3)
  ) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rank(out_rank), .out_bg(out_bg), .out_bank(out_bank), .out_row(out_row),
    .out_col(out_col), .out_offset(out_offset), .out_ignore(out_ignore), .out_oor(out_oor),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cur_mode(cur_mode), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  int          model_mode = 0;
  bit          err_exp = 0;
  bit          held_v = 0;
  logic [63:0] held;
  bit          last_acc;
  bit          last_cfg_fire;

  function automatic logic [63:0] pk(longint unsigned rank, longint unsigned bg,
                                     longint unsigned bank, longint unsigned row,
                                     longint unsigned col, longint unsigned off,
                                     longint unsigned ign, longint unsigned oor);
    return 64'((((((((rank * 4 + bg) * 4 + bank) * 8192 + row) * 1024 + col) * 8 + off) * 2 + ign) * 2) + oor);
  endfunction

  // Peel fields off the address from the LSB upward, in layout order.
  function automatic logic [63:0] model(logic [31:0] addr, int mode);
    longint unsigned a, off, col, bank, bg, row, rank, ign;
    a = 64'(addr);
    off = a % 8; a = a / 8;
    if (mode == 1) begin
      bg = a % 4; a = a / 4;
      col = a % 1024; a = a / 1024;
      bank = a % 4; a = a / 4;
    end else begin
      col = a % 1024; a = a / 1024;
      bank = a % 4; a = a / 4;
      bg = a % 4; a = a / 4;
    end
    row = a % 8192; a = a / 8192;
    rank = a % 2; a = a / 2;
    ign = a;
    if (mode == 2) begin
      bank = bank ^ (row % 4);
      bg = bg ^ ((row / 4) % 4);
    end
    return pk(rank, bg, bank, row, col, off, ign, (ign != 0) ? 1 : 0);
  endfunction

  function automatic logic [63:0] obs_fields();
    return {31'b0, out_rank, out_bg, out_bank, out_row, out_col, out_offset, out_ignore, out_oor};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock: check handshake/status outputs against the model, track traffic.
  task automatic cycle(input string tag);
    bit cfg_fire_e, in_rdy_e;
    logic [63:0] e;
    #1;
    cfg_fire_e = cfg_valid && (exp_q.size() == 0);
    in_rdy_e = !(exp_q.size() == 2 && !out_ready) && !cfg_fire_e;
    chk({tag, ":cfg_ready"}, 64'(cfg_ready), 64'(exp_q.size() == 0));
    chk({tag, ":in_ready"}, 64'(in_ready), 64'(in_rdy_e));
    chk({tag, ":cur_mode"}, 64'(cur_mode), 64'(model_mode));
    chk({tag, ":cfg_err"}, 64'(cfg_err), 64'(err_exp));
    if (exp_q.size() == 0) chk({tag, ":idle_out_valid"}, 64'(out_valid), 64'd0);
    if (held_v) begin
      chk({tag, ":stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ":stall_fields"}, obs_fields(), held);
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ":fields"}, obs_fields(), e);
    end
    held_v = out_valid && !out_ready;
    held = obs_fields();
    last_acc = in_valid && in_rdy_e;
    if (last_acc) exp_q.push_back(model(in_addr, model_mode));
    last_cfg_fire = cfg_fire_e;
    err_exp = cfg_fire_e && (cfg_mode == 2'd3);
    if (cfg_fire_e && cfg_mode != 2'd3) model_mode = int'(cfg_mode);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    bit done;
    done = 0;
    cfg_valid = 1'b1;
    cfg_mode = m;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle("set_mode");
      done = last_cfg_fire;
    end
    chk("set_mode_fired", 64'(done), 64'd1);
    cfg_valid = 1'b0;
  endtask

  // Issue one request into an empty pipeline; returns with it at the output.
  task automatic one_req(input string tag, input logic [31:0] a);
    in_valid = 1'b1;
    in_addr = a;
    out_ready = 1'b1;
    cycle(tag);
    in_valid = 1'b0;
    cycle(tag);
    chk({tag, ":latency2_valid"}, 64'(out_valid), 64'd1);
  endtask

  logic [31:0] stall_addrs[8];

  initial begin
    int idx;
    bit done;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; out_ready = 1'b0;
    cfg_valid = 1'b0; cfg_mode = 2'd0;
    tick(); tick();
    chk("reset:out_valid", 64'(out_valid), 64'd0);
    chk("reset:cur_mode", 64'(cur_mode), 64'd0);
    chk("reset:cfg_err", 64'(cfg_err), 64'd0);
    chk("reset:fields", obs_fields(), 64'd0);
    rst = 1'b0;

    one_req("m0", 32'h0000_6008);
    chk("m0:col", 64'(out_col), 64'h001);
    chk("m0:bank", 64'(out_bank), 64'd3);
    chk("m0:bg", 64'(out_bg), 64'd0);
    chk("m0:row_oor", 64'({out_row, out_oor}), 64'd0);
    cycle("m0_pop");

    // cfg and request together on an empty pipeline: cfg wins this cycle.
    cfg_valid = 1'b1; cfg_mode = 2'd1; in_valid = 1'b1; in_addr = 32'h0000_0028; out_ready = 1'b1;
    cycle("m1_cfg");
    cfg_valid = 1'b0;
    cycle("m1_req");
    chk("m1:accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    cycle("m1_wait");
    chk("m1:valid", 64'(out_valid), 64'd1);
    chk("m1:bg", 64'(out_bg), 64'd1);
    chk("m1:col", 64'(out_col), 64'h001);
    chk("m1:bank_off", 64'({out_bank, out_offset}), 64'd0);
    cycle("m1_pop");

    // cfg request held while two requests are in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 32'h1234_5678;
    cycle("inflight");
    in_addr = 32'h0abc_def0;
    cycle("inflight");
    in_valid = 1'b0; cfg_valid = 1'b1; cfg_mode = 2'd2;
    cycle("cfg_blocked");
    cycle("cfg_blocked");
    out_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle("cfg_drain");
      done = last_cfg_fire;
    end
    chk("cfg_drain:fired", 64'(done), 64'd1);
    cfg_valid = 1'b0;

    one_req("m2", 32'h0002_6008);
    chk("m2:row", 64'(out_row), 64'd1);
    chk("m2:bank", 64'(out_bank), 64'd2);
    chk("m2:bg_col", 64'({out_bg, out_col}), 64'h001);
    cycle("m2_pop");

    // Illegal mode: handshake completes, mode kept, one-cycle error pulse.
    cfg_valid = 1'b1; cfg_mode = 2'd3;
    cycle("cfg3");
    cfg_valid = 1'b0;
    cycle("cfg3_pulse");
    cycle("cfg3_after");
    chk("cfg3:mode_kept", 64'(cur_mode), 64'd2);

    set_mode(2'd0);
    one_req("oor", 32'h8000_0000);
    chk("oor:flag", 64'({out_ignore, out_oor}), 64'b11);
    chk("oor:rank_row", 64'({out_rank, out_row}), 64'd0);
    cycle("oor_pop");

    // Eight back-to-back requests with a three-cycle output stall.
    for (int i = 0; i < 8; i++) stall_addrs[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 40 && !(idx == 8 && exp_q.size() == 0); c++) begin
      in_valid = (idx < 8);
      in_addr = stall_addrs[idx % 8];
      out_ready = !(c >= 3 && c < 6);
      cycle("stall");
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall:all_accepted", 64'(idx), 64'd8);
    chk("stall:drained", 64'(exp_q.size()), 64'd0);

    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cycle("rand");
    end
    in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle("rand_drain");
    chk("rand:drained", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full and a non-zero mode.
    set_mode(2'd1);
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 32'h0000_6008;
    cycle("prerst");
    cycle("prerst");
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:cur_mode", 64'(cur_mode), 64'd0);
    chk("midrst:fields", obs_fields(), 64'd0);
    chk("midrst:cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    model_mode = 0; err_exp = 0; held_v = 0;
    out_ready = 1'b1;
    cycle("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_map_pipe.md
Name: addr_map_pipe

Overview:
- Parametrised, pipelined successor to the combinational DRAM address mapper.
- Decomposes a physical address into rank/BG/bank/row/col/offset/ignore under one of three runtime-selectable mapping modes, including XOR bank hashing.
- Sits between the request queue and the command FSM / row-open tracker.
- Valid/ready handshakes on both sides; mode changes are legal only when the pipeline is drained.

Parameters:
ADDR_W, 32, input address width
RANK_BITS, 1, rank field width
BG_BITS, 2, bank-group field width
BANK_BITS, 2, bank field width
ROW_BITS, 13, row field width; must be >= BANK_BITS+BG_BITS
COL_BITS, 10, column field width
OFFSET_BITS, 3, burst byte-offset width
IGNORE_BITS, ADDR_W-(sum of above), derived; must be >= 1

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_addr  in  ADDR_W  physical address
out_valid  out  1  decoded fields valid
out_ready  in  1  consumer accepts
out_rank/out_bg/out_bank/out_row/out_col/out_offset/out_ignore  out  field widths  decoded fields
out_oor  out  1  out of range: out_ignore != 0
cfg_valid  in  1  mode-change request
cfg_ready  out  1  high only when pipeline empty
cfg_mode  in  2  requested mode
cur_mode  out  2  active mode
cfg_err  out  1  one-cycle pulse: illegal mode accepted

Behaviour:
- Reset (sync, rst=1 at posedge):
  - s1_valid=0, s2_valid=0, cur_mode=0, cfg_err=0.
  - All out_* data fields = 0, out_valid=0.
  - Reset mid-operation discards in-flight requests.
- Pipeline:
  - Stage 1 registers in_addr and cur_mode.
  - Stage 2 registers decoded fields.
  - Latency exactly 2 cycles from accept to out_valid when there is no backpressure.
  - Full throughput: one request per cycle.
- Ready logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !(cfg_valid && cfg_ready).
  - Ready propagates combinationally backward; stages hold data while stalled.
  - out_* fields stable while out_valid && !out_ready.
- Field layout, fields listed LSB to MSB:
  - Mode 0 (RoRaBgBaCo): offset, col, bank, BG, row, rank, ignore.
  - Mode 1 (BG-interleave): offset, BG, col, bank, row, rank, ignore.
  - Mode 2 (XOR hash): mode 0 layout, then:
    - bank ^= row[BANK_BITS-1:0]
    - BG ^= row[BANK_BITS+BG_BITS-1:BANK_BITS]
    - row, col, rank, offset unchanged.
  - The mode captured in stage 1 governs decode, so a request is never decoded under a different mode.
- Configuration:
  - cfg_ready = !s1_valid && !s2_valid.
  - On cfg_valid && cfg_ready with cfg_mode in {0,1,2}: cur_mode updates at next edge.
  - cfg_mode=3: handshake completes, cur_mode unchanged, cfg_err=1 for one cycle.
  - Simultaneous cfg_valid and in_valid with an empty pipeline: cfg wins, in_ready=0 that cycle, request taken next cycle under the new mode.
  - cfg_valid while the pipeline is non-empty: cfg_ready=0, requests continue to flow.
- out_oor is informational only; the request still flows through.

Test Plan:
- Mode 0, in_addr=0x0000_6008, out_ready=1 -> two cycles later out_valid=1, offset=0, col=0x001, bank=3, bg=0, row=0, rank=0, oor=0.
- Mode 1 via cfg (cfg_mode=1), in_addr=0x0000_0028 -> bg=1, col=0x001, bank=0, offset=0.
- Mode 2, in_addr=0x0002_6008 -> row=1, bank=2 (3^1), bg=0, col=0x001.
- Back-to-back 8 requests with out_ready held 0 for 3 cycles mid-stream -> no loss or duplication, order preserved, fields stable while stalled, in_ready=0 when both stages full.
- in_addr=0x8000_0000 -> ignore=1, oor=1, rank=0, row=0.
- cfg_valid with two requests in flight -> cfg_ready=0 until drained. cfg_mode=3 -> cfg_err pulses 1 cycle, cur_mode unchanged. rst asserted with s1/s2 full -> out_valid=0 next cycle, cur_mode=0.
